// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the dual-channel waveform sequencer.
//   mode_e        : waveform mode codes driven to the output demux
//   chan_state_e  : per-channel sequencing state
//   ADDR_*        : register bus addresses
//   MODE_MAX      : highest legal mode code
package wave_seq_pkg;

  typedef enum logic [2:0] {
    MODE_DC     = 3'd0,
    MODE_SINE   = 3'd1,
    MODE_SAW    = 3'd2,
    MODE_TRI    = 3'd3,
    MODE_SQUARE = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    RUN       = 3'd2,
    SWITCH    = 3'd3,
    STOP_PEND = 3'd4
  } chan_state_e;

  localparam logic [2:0] ADDR_MODE    = 3'd0;
  localparam logic [2:0] ADDR_CMD     = 3'd1;
  localparam logic [2:0] ADDR_DIV     = 3'd2;
  localparam logic [2:0] ADDR_BURST_A = 3'd3;
  localparam logic [2:0] ADDR_BURST_B = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  localparam logic [2:0] MODE_MAX = MODE_SQUARE;

  function automatic logic mode_ok(input logic [2:0] m);
    return m <= MODE_MAX;
  endfunction

endpackage

// File: rtl/wave_seq_chan_fsm.sv
// One output channel: start/stop/mode-switch sequencing plus burst counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : sample strobe; all mode/run changes happen on it
//   wrap       : generator period-boundary pulse (qualified by en)
//   start/stop : single-cycle commands from the CMD register
//   pending    : mode requested through the MODE register
//   burst      : burst length, 0 = continuous
//   active     : mode currently driven to the demux
//   run        : channel running
//   done_set   : one-cycle pulse when a stop completes on a boundary
module wave_seq_chan_fsm
  import wave_seq_pkg::*;
#(
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               wrap,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         pending,
  input  logic [BURST_W-1:0] burst,
  output logic [2:0]         active,
  output logic               run,
  output logic               done_set
);

  chan_state_e        state_q, state_d;
  logic [2:0]         active_q, active_d;
  logic               run_q, run_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               expire;
  logic               start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      run_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    expire   = 1'b0;
    // A stop in the same write as a start overrides it.
    start_ok = start && !stop;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = ARM;
      end
      ARM: begin
        if (stop) begin
          state_d = IDLE;
        end else if (en) begin
          active_d = pending;
          run_d    = 1'b1;
          cnt_d    = burst;
          state_d  = RUN;
        end
      end
      RUN, SWITCH: begin
        // A zero count means continuous; a burst run counts down to 0.
        if (en && (cnt_q != '0)) begin
          cnt_d  = cnt_q - BURST_W'(1);
          expire = (cnt_q == BURST_W'(1));
        end
        if (stop || expire) begin
          state_d = STOP_PEND;
        end else if (state_q == SWITCH) begin
          if (en && wrap) begin
            active_d = pending;
            state_d  = RUN;
          end
        end else if (pending != active_q) begin
          state_d = SWITCH;
        end
      end
      STOP_PEND: begin
        if (start_ok) begin
          state_d = RUN;
        end else if (en && wrap) begin
          run_d    = 1'b0;
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = active_q;
  assign run    = run_q;

endmodule

// File: rtl/wave_channel_sequencer.sv
// Dual-channel output demux controller with a small register bus.
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en/addr/wr_data : register write port; addr also selects the read
//   rd_data          : registered read data, one cycle after addr
//   wrap_a, wrap_b   : generator period-boundary pulses
//   mode             : [2:0] ch A mode, [5:3] ch B mode
//   run              : [0] ch A run, [1] ch B run
//   en               : sample strobe, one cycle every DIV+1 cycles
//   done_irq         : level, any STATUS.done bit set
module wave_channel_sequencer
  import wave_seq_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        wrap_a,
  input  logic        wrap_b,
  output logic [31:0] mode,
  output logic [31:0] run,
  output logic        en,
  output logic        done_irq
);

  logic [2:0]         pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [DIV_W-1:0]   div_q, div_d, cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_a_q, burst_a_d, burst_b_q, burst_b_d;
  logic [1:0]         done_q, done_d;
  logic               mode_err_q, mode_err_d;
  logic               en_q, en_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic wr_mode, wr_cmd, wr_div, wr_burst_a, wr_burst_b, wr_status;
  logic [2:0] act_a, act_b;
  logic run_a, run_b, done_set_a, done_set_b;
  logic unused_wr_data;

  assign wr_mode    = wr_en && (addr == ADDR_MODE);
  assign wr_cmd     = wr_en && (addr == ADDR_CMD);
  assign wr_div     = wr_en && (addr == ADDR_DIV);
  assign wr_burst_a = wr_en && (addr == ADDR_BURST_A);
  assign wr_burst_b = wr_en && (addr == ADDR_BURST_B);
  assign wr_status  = wr_en && (addr == ADDR_STATUS);
  assign unused_wr_data = ^wr_data;

  wave_seq_chan_fsm #(.BURST_W(BURST_W)) u_chan_a (
    .clk(clk), .rst_n(rst_n), .en(en_q), .wrap(wrap_a),
    .start(wr_cmd && wr_data[0]), .stop(wr_cmd && wr_data[2]),
    .pending(pend_a_q), .burst(burst_a_q),
    .active(act_a), .run(run_a), .done_set(done_set_a)
  );

  wave_seq_chan_fsm #(.BURST_W(BURST_W)) u_chan_b (
    .clk(clk), .rst_n(rst_n), .en(en_q), .wrap(wrap_b),
    .start(wr_cmd && wr_data[1]), .stop(wr_cmd && wr_data[3]),
    .pending(pend_b_q), .burst(burst_b_q),
    .active(act_b), .run(run_b), .done_set(done_set_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a_q   <= '0;
      pend_b_q   <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      burst_a_q  <= '0;
      burst_b_q  <= '0;
      done_q     <= '0;
      mode_err_q <= 1'b0;
      en_q       <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      burst_a_q  <= burst_a_d;
      burst_b_q  <= burst_b_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
      en_q       <= en_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    div_d      = div_q;
    burst_a_d  = burst_a_q;
    burst_b_d  = burst_b_q;
    done_d     = done_q;
    mode_err_d = mode_err_q;
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    rd_data_d  = '0;

    // Illegal mode fields are dropped individually; the legal one still lands.
    if (wr_mode) begin
      if (mode_ok(wr_data[2:0])) pend_a_d = wr_data[2:0];
      else                       mode_err_d = 1'b1;
      if (mode_ok(wr_data[5:3])) pend_b_d = wr_data[5:3];
      else                       mode_err_d = 1'b1;
    end
    if (wr_burst_a) burst_a_d = wr_data[BURST_W-1:0];
    if (wr_burst_b) burst_b_d = wr_data[BURST_W-1:0];

    // W1C clear first so a same-cycle completion still sets the bit.
    if (wr_status) begin
      done_d = done_q & ~wr_data[3:2];
      if (wr_data[4]) mode_err_d = 1'b0;
    end
    done_d = done_d | {done_set_b, done_set_a};

    // Strobe divider: a DIV write restarts the count so the next strobe
    // is exactly DIV+1 cycles away.
    if (wr_div) begin
      div_d = wr_data[DIV_W-1:0];
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
      en_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    case (addr)
      ADDR_MODE:    rd_data_d[5:0]         = {pend_b_q, pend_a_q};
      ADDR_DIV:     rd_data_d[DIV_W-1:0]   = div_q;
      ADDR_BURST_A: rd_data_d[BURST_W-1:0] = burst_a_q;
      ADDR_BURST_B: rd_data_d[BURST_W-1:0] = burst_b_q;
      ADDR_STATUS:  rd_data_d[4:0]         = {mode_err_q, done_q, run_b, run_a};
      default:      rd_data_d              = '0;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign en       = en_q;
  assign mode     = {26'd0, act_b, act_a};
  assign run      = {30'd0, run_b, run_a};
  assign done_irq = |done_q;

endmodule

// File: tb/tb_wave_channel_sequencer.sv
module tb_wave_channel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wrap_a = 1'b0;
  logic        wrap_b = 1'b0;
  logic [31:0] rd_data, mode, run;
  logic        en, done_irq;

  int n_chk = 0;
  int n_err = 0;

  wave_channel_sequencer #(.DIV_W(16), .BURST_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .wrap_a(wrap_a), .wrap_b(wrap_b), .mode(mode),
    .run(run), .en(en), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // Behavioural reference: per-channel flags instead of a state code,
  // and the strobe as a countdown of cycles remaining.
  bit          m_armed[2], m_running[2], m_switching[2], m_stopping[2], m_done[2];
  logic [2:0]  m_act[2], m_pend[2];
  int          m_left_b[2], m_burst[2];
  bit          m_err, m_en;
  int          m_div, m_left;
  logic [31:0] m_rd;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_armed[c] = 0; m_running[c] = 0; m_switching[c] = 0; m_stopping[c] = 0;
      m_done[c] = 0; m_act[c] = 3'd0; m_pend[c] = 3'd0; m_left_b[c] = 0; m_burst[c] = 0;
    end
    m_err = 0; m_en = 0; m_div = 0; m_left = 0; m_rd = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] rd;
    bit strobe, cmd, st, sp, wp, expire;
    bit dset[2];
    strobe = m_en;
    case (addr)
      3'd0: rd = {26'd0, m_pend[1], m_pend[0]};
      3'd2: rd = 32'(m_div);
      3'd3: rd = 32'(m_burst[0]);
      3'd4: rd = 32'(m_burst[1]);
      3'd5: rd = {27'd0, m_err, m_done[1], m_done[0], m_running[1], m_running[0]};
      default: rd = 32'd0;
    endcase
    m_rd = rd;
    cmd = wr_en && (addr == 3'd1);
    for (int c = 0; c < 2; c++) begin
      st = cmd && wr_data[c] && !wr_data[c+2];
      sp = cmd && wr_data[c+2];
      wp = (c == 0) ? wrap_a : wrap_b;
      dset[c] = 0;
      if (m_stopping[c]) begin
        if (st) m_stopping[c] = 0;
        else if (strobe && wp) begin
          m_stopping[c] = 0; m_running[c] = 0; dset[c] = 1;
        end
      end else if (m_running[c]) begin
        expire = 0;
        if (strobe && m_left_b[c] > 0) begin
          m_left_b[c]--;
          expire = (m_left_b[c] == 0);
        end
        if (sp || expire) begin
          m_stopping[c] = 1; m_switching[c] = 0;
        end else if (m_switching[c]) begin
          if (strobe && wp) begin m_act[c] = m_pend[c]; m_switching[c] = 0; end
        end else if (m_pend[c] != m_act[c]) begin
          m_switching[c] = 1;
        end
      end else if (m_armed[c]) begin
        if (sp) m_armed[c] = 0;
        else if (strobe) begin
          m_armed[c] = 0; m_running[c] = 1; m_act[c] = m_pend[c]; m_left_b[c] = m_burst[c];
        end
      end else if (st) begin
        m_armed[c] = 1;
      end
    end
    if (wr_en) begin
      case (addr)
        3'd0: begin
          if (wr_data[2:0] <= 3'd4) m_pend[0] = wr_data[2:0]; else m_err = 1;
          if (wr_data[5:3] <= 3'd4) m_pend[1] = wr_data[5:3]; else m_err = 1;
        end
        3'd2: m_div = int'(wr_data[15:0]);
        3'd3: m_burst[0] = int'(wr_data[15:0]);
        3'd4: m_burst[1] = int'(wr_data[15:0]);
        3'd5: begin
          if (wr_data[2]) m_done[0] = 0;
          if (wr_data[3]) m_done[1] = 0;
          if (wr_data[4]) m_err = 0;
        end
        default: ;
      endcase
    end
    for (int c = 0; c < 2; c++) if (dset[c]) m_done[c] = 1;
    if (wr_en && addr == 3'd2) begin
      m_left = int'(wr_data[15:0]);
      m_en = 0;
    end else if (m_left == 0) begin
      m_en = 1;
      m_left = m_div;
    end else begin
      m_en = 0;
      m_left--;
    end
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [97:0] exp_vec();
    return {26'd0, m_act[1], m_act[0], 30'd0, m_running[1], m_running[0],
            m_en, m_done[0] | m_done[1], m_rd};
  endfunction

  wire [97:0] dut_vec = {mode, run, en, done_irq, rd_data};

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (dut_vec !== 98'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", dut_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (en !== 1'b1) begin
      n_err++; $display("FAIL reset_first_en got=%b want=1", en);
    end
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_startup();
    int last = -1;
    bit seen = 0, loaded = 0;
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h0A);
    wr(3'd1, 32'h1);
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL startup_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec());
      end
      if (!seen) begin
        n_chk++;
        if (run[0] !== 1'b0) begin
          n_err++; $display("FAIL startup_run_early got=%b want=0", run[0]);
        end
      end else if (!loaded) begin
        loaded = 1;
        n_chk++;
        if (mode[2:0] !== 3'd2 || run[0] !== 1'b1) begin
          n_err++; $display("FAIL startup_load mode=%0d run=%b want mode=2 run=1", mode[2:0], run[0]);
        end
      end
      if (en === 1'b1) begin
        if (last >= 0) begin
          n_chk++;
          if (i - last != 4) begin
            n_err++; $display("FAIL startup_en_period got=%0d want=4", i - last);
          end
        end
        last = i;
        seen = 1;
      end
      @(negedge clk);
    end
    n_chk++;
    if (run[1] !== 1'b0 || mode[5:3] !== 3'd0) begin
      n_err++; $display("FAIL startup_chb_idle run=%b mode=%0d want 0,0", run[1], mode[5:3]);
    end
  endtask

  task automatic test_switch();
    int ens = 0;
    bit wrapped = 0;
    wr(3'd0, 32'h0C);
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (mode[2:0] !== (wrapped ? 3'd4 : 3'd2) || run[0] !== 1'b1) begin
        n_err++; $display("FAIL switch_mode got=%0d run=%b want=%0d run=1", mode[2:0], run[0], wrapped ? 4 : 2);
      end
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL switch_model got=%h want=%h", dut_vec, exp_vec());
      end
      if (en === 1'b1) ens++;
      wrap_a = (en === 1'b1) && (ens == 2);
      @(negedge clk);
      if (wrap_a) wrapped = 1;
    end
    wrap_a = 1'b0;
  endtask

  task automatic test_burst();
    int ens = 0, k = 0;
    do_reset();
    wr(3'd3, 32'd5);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h1);
    for (int i = 0; i < 30; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL burst_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec());
      end
      if (run[0] === 1'b1 && en === 1'b1) k++;
      if (en === 1'b1) begin ens++; wrap_a = (ens % 3 == 0); end
      else wrap_a = 1'b0;
      @(negedge clk);
    end
    wrap_a = 1'b0;
    n_chk++;
    if (k != 8 || run[0] !== 1'b0 || done_irq !== 1'b1) begin
      n_err++; $display("FAIL burst_end en_while_run=%0d run=%b irq=%b want 8,0,1", k, run[0], done_irq);
    end
    addr = 3'd5;
    @(negedge clk);
    n_chk++;
    if (rd_data[3:2] !== 2'b01) begin
      n_err++; $display("FAIL burst_status_done got=%b want=01", rd_data[3:2]);
    end
    wr(3'd5, 32'h4);
    @(negedge clk);
    n_chk++;
    if (rd_data[3:2] !== 2'b00 || done_irq !== 1'b0) begin
      n_err++; $display("FAIL burst_w1c done=%b irq=%b want 00,0", rd_data[3:2], done_irq);
    end
  endtask

  task automatic test_mode_err();
    wr(3'd0, 32'h0A);
    wr(3'd0, 32'h3F);
    @(negedge clk);
    n_chk++;
    if (rd_data[5:0] !== 6'h0A) begin
      n_err++; $display("FAIL moderr_keep got=%h want=0a", rd_data[5:0]);
    end
    addr = 3'd5;
    @(negedge clk);
    n_chk++;
    if (rd_data[4] !== 1'b1) begin
      n_err++; $display("FAIL moderr_flag got=%b want=1", rd_data[4]);
    end
    wr(3'd0, 32'h25);
    @(negedge clk);
    n_chk++;
    if (rd_data[5:0] !== 6'h22) begin
      n_err++; $display("FAIL moderr_partial got=%h want=22", rd_data[5:0]);
    end
    wr(3'd5, 32'h10);
    @(negedge clk);
    n_chk++;
    if (rd_data[4] !== 1'b0) begin
      n_err++; $display("FAIL moderr_w1c got=%b want=0", rd_data[4]);
    end
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL moderr_model got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_stop_cancel();
    do_reset();
    wr(3'd0, 32'h0A);
    wr(3'd1, 32'h3);
    repeat (4) @(negedge clk);
    n_chk++;
    if (run[1:0] !== 2'b11) begin
      n_err++; $display("FAIL cancel_both_run got=%b want=11", run[1:0]);
    end
    wrap_b = 1'b1;
    wr(3'd1, 32'hC);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL cancel_model got=%h want=%h", dut_vec, exp_vec());
      end
      @(negedge clk);
    end
    wrap_b = 1'b0;
    addr = 3'd5;
    @(negedge clk);
    n_chk++;
    if (rd_data[3:0] !== 4'b1001) begin
      n_err++; $display("FAIL cancel_stop_b status=%b want=1001", rd_data[3:0]);
    end
    wr(3'd1, 32'h1);
    wrap_a = 1'b1;
    addr = 3'd5;
    repeat (5) @(negedge clk);
    n_chk++;
    if (run[0] !== 1'b1 || rd_data[2] !== 1'b0) begin
      n_err++; $display("FAIL cancel_restart run=%b done_a=%b want 1,0", run[0], rd_data[2]);
    end
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL cancel_end_model got=%h want=%h", dut_vec, exp_vec());
    end
    wrap_a = 1'b0;
  endtask

  task automatic test_async_reset();
    n_chk++;
    if (run[0] !== 1'b1) begin
      n_err++; $display("FAIL areset_pre run=%b want=1", run[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (mode !== 32'd0 || run !== 32'd0 || en !== 1'b0 || done_irq !== 1'b0) begin
      n_err++; $display("FAIL areset_immediate mode=%h run=%h en=%b irq=%b want zeros", mode, run, en, done_irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (en !== 1'b0) begin
      n_err++; $display("FAIL areset_release_en got=%b want=0", en);
    end
    @(negedge clk);
    n_chk++;
    if (en !== 1'b1) begin
      n_err++; $display("FAIL areset_first_en got=%b want=1", en);
    end
  endtask

  task automatic test_random();
    logic [2:0] a;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
      a = 3'($urandom_range(0, 7));
      addr = a;
      wr_en = ($urandom_range(0, 3) == 0);
      case (a)
        3'd0: wr_data = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 63))
                                                    : {26'd0, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
        3'd1: wr_data = 32'($urandom_range(0, 15));
        3'd2: wr_data = 32'($urandom_range(0, 3));
        3'd3, 3'd4: wr_data = 32'($urandom_range(0, 6));
        default: wr_data = 32'($urandom_range(0, 31));
      endcase
      wrap_a = ($urandom_range(0, 2) == 0);
      wrap_b = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; wrap_a = 1'b0; wrap_b = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_startup();
    test_switch();
    test_burst();
    test_mode_err();
    test_stop_cancel();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
